// File: rtl/hilo_mult_sequencer_pkg.sv
// Shared encodings for the HI/LO multiply sequencer: opcodes, FSM states and
// iteration-count helpers.
package hilo_mult_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_MADD  = 3'b010,
        OP_MSUB  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_RSV6  = 3'b110,
        OP_RSV7  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ACCUM = 2'd2
    } state_e;

    localparam int unsigned STEP_DEFAULT = 2;
    localparam int unsigned N = 32 / STEP_DEFAULT;

    function automatic int unsigned n_iter(input int unsigned step);
        return 32 / step;
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/hilo_mult_sequencer_mult_step.sv
// One shift-add iteration: adds the partial products of a STEP-bit multiplier
// slice against the pre-shifted multiplicand onto the running product.
module mult_step #(
    parameter int unsigned STEP = 2
) (
    input  logic [63:0]     i_product,
    input  logic [63:0]     i_mcand,
    input  logic [STEP-1:0] i_slice,
    output logic [63:0]     o_next
);

    logic [63:0] w_pp;

    always_comb begin
        w_pp = '0;
        for (int unsigned j = 0; j < STEP; j++) begin
            if (i_slice[j]) begin
                w_pp = w_pp + (i_mcand << j);
            end
        end
    end

    assign o_next = i_product + w_pp;

endmodule

// File: rtl/hilo_mult_sequencer.sv
// HI/LO owner: iterative signed/unsigned multiply with accumulate/subtract,
// MTHI/MTLO writes, and a stall request for MFHI/MFLO against stale HI/LO.
module hilo_mult_sequencer
    import hilo_mult_sequencer_pkg::*;
#(
    parameter int unsigned STEP = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HiLoRead,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Done,
    output logic        Stall
);

    localparam int unsigned N_ITER = n_iter(STEP);
    localparam int unsigned CNT_W  = $clog2(N_ITER + 1);

    state_e             r_state;
    op_e                r_op;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               r_done;
    logic [63:0]        r_prod;
    logic [63:0]        r_mcand;
    logic [31:0]        r_mplier;
    logic               r_neg;
    logic [CNT_W-1:0]   r_cnt;

    op_e                w_op;
    logic               w_signed;
    logic [31:0]        w_abs_a;
    logic [31:0]        w_abs_b;
    logic [63:0]        w_next;
    logic [63:0]        w_res;

    assign w_op     = op_e'(Op);
    assign w_signed = (w_op != OP_MULTU);
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign w_abs_a  = (w_signed && A[31]) ? -A : A;
    assign w_abs_b  = (w_signed && B[31]) ? -B : B;
    assign w_res    = r_neg ? -r_prod : r_prod;

    mult_step #(.STEP(STEP)) u_step (
        .i_product (r_prod),
        .i_mcand   (r_mcand),
        .i_slice   (r_mplier[STEP-1:0]),
        .o_next    (w_next)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_MULT;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        case (w_op)
                            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                                r_mcand  <= {32'b0, w_abs_a};
                                r_mplier <= w_abs_b;
                                r_neg    <= w_signed & (A[31] ^ B[31]);
                                r_op     <= w_op;
                                r_prod   <= '0;
                                r_cnt    <= CNT_W'(N_ITER);
                                r_state  <= S_CALC;
                            end
                            OP_MTHI: r_hi <= A;
                            OP_MTLO: r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    r_prod   <= w_next;
                    r_mplier <= r_mplier >> STEP;
                    r_mcand  <= r_mcand << STEP;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    case (r_op)
                        OP_MADD: {r_hi, r_lo} <= {r_hi, r_lo} + w_res;
                        OP_MSUB: {r_hi, r_lo} <= {r_hi, r_lo} - w_res;
                        default: {r_hi, r_lo} <= w_res;
                    endcase
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Hi    = r_hi;
    assign Lo    = r_lo;
    assign Done  = r_done;
    assign Busy  = (r_state != S_IDLE);
    assign Stall = HiLoRead & (Busy | (Start & is_mul_op(Op) & (r_state == S_IDLE)));

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Self-checking bench for hilo_mult_sequencer: directed cases plus random ops
// against a 64-bit HI:LO arithmetic reference model.
module tb_hilo_mult_sequencer;

    localparam int N = 16;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiLoRead;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;
    logic        Stall;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [63:0] m_hilo  = '0;

    hilo_mult_sequencer #(.STEP(2)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .Op       (Op),
        .A        (A),
        .B        (B),
        .HiLoRead (HiLoRead),
        .Hi       (Hi),
        .Lo       (Lo),
        .Busy     (Busy),
        .Done     (Done),
        .Stall    (Stall)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Full-width arithmetic product, signed or unsigned by opcode.
    function automatic logic [63:0] ref_prod(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa;
        longint sb;
        if (op == 3'b001) return {32'b0, a} * {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Called just after a falling edge; returns in the Done cycle.
    task automatic do_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inj);
        logic [63:0] p;
        logic [63:0] old;
        p   = ref_prod(op, a, b);
        old = m_hilo;
        case (op)
            3'b010:  m_hilo = old + p;
            3'b011:  m_hilo = old - p;
            default: m_hilo = p;
        endcase
        Start = 1'b1; Op = op; A = a; B = b;
        #1;
        chk("stall_issue", Stall, HiLoRead);
        @(negedge Clk);
        Start = 1'b0;
        for (int c = 0; c <= N + 1; c++) begin
            if (inj && c == 5) begin
                Start = 1'b1; Op = 3'b101; A = 32'h1234;
            end
            if (inj && c == 6) Start = 1'b0;
            #1;
            chk("busy", Busy, c <= N);
            chk("done", Done, c == N + 1);
            chk("stall", Stall, HiLoRead && (c <= N));
            if (c <= N) begin
                chk("hilo_hold", {Hi, Lo}, old);
                @(negedge Clk);
            end
        end
        chk("hilo", {Hi, Lo}, m_hilo);
    endtask

    task automatic do_simple(input logic [2:0] op, input logic [31:0] a);
        Start = 1'b1; Op = op; A = a; B = $urandom;
        #1;
        chk("stall_nomul", Stall, 1'b0);
        @(negedge Clk);
        Start = 1'b0;
        #1;
        if (op == 3'b100) m_hilo[63:32] = a;
        if (op == 3'b101) m_hilo[31:0]  = a;
        chk("hilo_simple", {Hi, Lo}, m_hilo);
        chk("busy_simple", Busy, 1'b0);
        chk("done_simple", Done, 1'b0);
    endtask

    task automatic step_check_no_done();
        @(negedge Clk);
        #1;
        chk("done_pulse", Done, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        Rst = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0; HiLoRead = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        chk("rst_hilo", {Hi, Lo}, 64'h0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_stall", Stall, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        do_mul(3'b000, 32'hFFFFFFFD, 32'd5, 1'b0);
        chk("mult_neg3x5", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFF1);
        step_check_no_done();

        do_mul(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk("multu_max", {Hi, Lo}, 64'hFFFFFFFE_00000001);
        step_check_no_done();

        do_mul(3'b000, 32'h80000000, 32'h80000000, 1'b0);
        chk("mult_min", {Hi, Lo}, 64'h40000000_00000000);
        step_check_no_done();

        do_simple(3'b100, 32'h0);
        do_simple(3'b101, 32'd10);
        do_mul(3'b010, 32'd4, 32'hFFFFFFFE, 1'b0);
        chk("madd", {Hi, Lo}, 64'h0000000000000002);
        do_mul(3'b011, 32'd1, 32'd3, 1'b0);
        chk("msub", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFF);
        step_check_no_done();

        do_mul(3'b000, 32'd7, 32'd9, 1'b1);
        chk("mtlo_while_busy", {Hi, Lo}, 64'd63);
        step_check_no_done();

        HiLoRead = 1'b1;
        do_mul(3'b000, 32'd11, 32'd13, 1'b0);
        HiLoRead = 1'b0;
        step_check_no_done();

        do_simple(3'b100, 32'h11);
        do_simple(3'b101, 32'h22);
        do_simple(3'b110, 32'hDEAD);
        do_simple(3'b111, 32'hBEEF);
        Start = 1'b1; Op = 3'b000; A = 32'd2; B = 32'd3;
        @(negedge Clk);
        Start = 1'b0;
        repeat (7) @(negedge Clk);
        Rst = 1'b1;
        #1;
        m_hilo = '0;
        chk("abort_hilo", {Hi, Lo}, 64'h0);
        chk("abort_busy", Busy, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            #1;
            chk("abort_no_done", Done, 1'b0);
        end
        do_mul(3'b000, 32'd2, 32'd3, 1'b0);
        chk("after_abort", {Hi, Lo}, 64'd6);
        step_check_no_done();

        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            HiLoRead = 1'($urandom);
            op = 3'($urandom_range(0, 7));
            if (op[2] == 1'b0) begin
                do_mul(op, pick_operand(), pick_operand(), 1'b0);
                if ($urandom_range(0, 1) == 1) step_check_no_done();
            end else begin
                do_simple(op, $urandom);
            end
        end
        HiLoRead = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
